// File: rtl/balance_cntrl.sv
// PID balance controller: pitch samples in, saturated left/right motor speed commands out.
// Stage 1 captures error/integrator/derivative on vld; stage 2 registers the steered outputs.
module balance_cntrl #(
  parameter logic        [4:0]  P_COEFF     = 5'd12,
  parameter logic        [5:0]  D_COEFF     = 6'd7,
  parameter logic signed [11:0] FAST_THRESH = 12'sd1536
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld,
  input  logic signed [15:0] ptch,
  input  logic signed [11:0] ld_cell_diff,
  input  logic               en_steer,
  input  logic               rider_off,
  input  logic               pwr_up,
  output logic signed [11:0] lft_spd,
  output logic signed [11:0] rght_spd,
  output logic               too_fast
);

  logic signed [9:0]  err_sat;
  logic signed [9:0]  err_reg;
  logic signed [9:0]  prev_err;
  logic signed [17:0] integrator;
  logic signed [17:0] int_sum;
  logic               int_ovf;
  logic signed [10:0] d_diff;
  logic signed [6:0]  d_sat;
  logic signed [12:0] d_prod;
  logic signed [12:0] d_reg;
  logic               vld_ff;

  logic signed [14:0] p_term;
  logic signed [14:0] i_term;
  logic signed [14:0] d_term;
  logic signed [15:0] pid;
  logic signed [15:0] steer;
  logic signed [15:0] lft;
  logic signed [15:0] rght;
  logic signed [11:0] lft_sat;
  logic signed [11:0] rght_sat;

  // prev_err is sample history only, and the low three load-cell bits vanish in the shift.
  logic unused_bits;
  assign unused_bits = ^{prev_err, ld_cell_diff[2:0]};

  function automatic logic signed [11:0] sat12(input logic signed [15:0] v);
    if (v > 16'sd2047)       return 12'sh7ff;
    else if (v < -16'sd2048) return 12'sh800;
    else                     return v[11:0];
  endfunction

  // NOTE: always_comb assigns every output on every path, so no latch is inferred.
  always_comb begin
    err_sat = ptch[9:0];
    if (ptch > 16'sd511)       err_sat = 10'sd511;
    else if (ptch < -16'sd512) err_sat = -10'sd512;

    d_diff = $signed({err_sat[9], err_sat}) - $signed({err_reg[9], err_reg});
    d_sat  = d_diff[6:0];
    if (d_diff > 11'sd63)       d_sat = 7'sd63;
    else if (d_diff < -11'sd64) d_sat = -7'sd64;
  end

  assign d_prod  = $signed({{6{d_sat[6]}}, d_sat}) * $signed({7'd0, D_COEFF});
  assign int_sum = integrator + $signed({{8{err_sat[9]}}, err_sat});
  // Same-sign operands producing a flipped sign means the add wrapped; hold instead.
  assign int_ovf = (integrator[17] == err_sat[9]) && (int_sum[17] != integrator[17]);

  assign p_term = $signed({{5{err_reg[9]}}, err_reg}) * $signed({10'd0, P_COEFF});
  assign i_term = $signed({{3{integrator[17]}}, integrator[17:6]});
  assign d_term = $signed({{2{d_reg[12]}}, d_reg});
  assign pid    = 16'(p_term) + 16'(i_term) + 16'(d_term);
  assign steer  = $signed({{7{ld_cell_diff[11]}}, ld_cell_diff[11:3]});
  assign lft    = en_steer ? pid - steer : pid;
  assign rght   = en_steer ? pid + steer : pid;
  assign lft_sat  = sat12(lft);
  assign rght_sat = sat12(rght);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_reg    <= '0;
      prev_err   <= '0;
      d_reg      <= '0;
      integrator <= '0;
      vld_ff     <= 1'b0;
    end else begin
      vld_ff <= vld;
      if (vld) begin
        err_reg  <= err_sat;
        prev_err <= err_reg;
        d_reg    <= d_prod;
      end
      if (!pwr_up || rider_off)  integrator <= '0;
      else if (vld && !int_ovf)  integrator <= int_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lft_spd  <= '0;
      rght_spd <= '0;
      too_fast <= 1'b0;
    end else if (!pwr_up) begin
      lft_spd  <= '0;
      rght_spd <= '0;
      too_fast <= 1'b0;
    end else if (vld_ff) begin
      lft_spd  <= lft_sat;
      rght_spd <= rght_sat;
      too_fast <= (lft_sat > FAST_THRESH) || (rght_sat > FAST_THRESH);
    end
  end

endmodule
